// File: rtl/rv_plic_gw_arb.sv
// PLIC core: per-source gateways (level / edge / counted-edge) feeding per-target
// priority arbiters, with a same-cycle claim resolver and complete handling.
//
// state      | meaning
// GwIdle     | no request outstanding; waiting for a trigger or a stored edge count
// GwPending  | request visible on ip_o and offered to the arbiters
// GwClaimed  | handed to a target; waits for a matching complete
module rv_plic_gw_arb #(
  parameter int unsigned NumSrc    = 32,
  parameter int unsigned NumTarget = 2,
  parameter int unsigned PrioW     = 3,
  parameter int unsigned CntW      = 4,
  localparam int unsigned IdW      = $clog2(NumSrc + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumSrc-1:0]             intr_src_i,
  input  logic [2*NumSrc-1:0]           mode_i,
  input  logic [PrioW*NumSrc-1:0]       prio_i,
  input  logic [NumSrc*NumTarget-1:0]   ie_i,
  input  logic [PrioW*NumTarget-1:0]    threshold_i,
  input  logic [NumTarget-1:0]          claim_req_i,
  output logic [IdW*NumTarget-1:0]      claim_id_o,
  input  logic [NumTarget-1:0]          complete_i,
  input  logic [IdW*NumTarget-1:0]      complete_id_i,
  input  logic [NumSrc-1:0]             ovf_clr_i,
  output logic [NumSrc-1:0]             ip_o,
  output logic [NumTarget-1:0]          irq_o,
  output logic [IdW*NumTarget-1:0]      irq_id_o,
  output logic [NumSrc-1:0]             cnt_ovf_o
);

  typedef enum logic [1:0] {
    GwIdle    = 2'd0,
    GwPending = 2'd1,
    GwClaimed = 2'd2
  } gw_state_e;

  logic [NumSrc-1:0]          pend;
  logic [NumSrc-1:0]          gnt_src;
  logic [NumSrc-1:1]          cmpl_src;
  logic [NumTarget-1:0]       conflict;
  logic [NumTarget-1:0]       irq_q;
  logic [IdW*NumTarget-1:0]   irq_id_q;
  logic [PrioW*NumTarget-1:0] best_prio;
  logic [IdW*NumTarget-1:0]   best_id;
  logic                       unused_src0;

  assign unused_src0  = ^{intr_src_i[0], mode_i[1:0], ovf_clr_i[0]};
  assign pend[0]      = 1'b0;
  assign cnt_ovf_o[0] = 1'b0;

  // Lower-index targets win when several claim the same ID in one cycle.
  always_comb begin
    gnt_src    = '0;
    conflict   = '0;
    claim_id_o = '0;
    for (int t = 0; t < NumTarget; t++) begin
      for (int u = 0; u < t; u++) begin
        if (claim_req_i[u] && irq_id_q[u*IdW +: IdW] == irq_id_q[t*IdW +: IdW]) begin
          conflict[t] = 1'b1;
        end
      end
      for (int s = 1; s < NumSrc; s++) begin
        if (claim_req_i[t] && !conflict[t] && pend[s] &&
            irq_id_q[t*IdW +: IdW] == IdW'(s)) begin
          gnt_src[s]                = 1'b1;
          claim_id_o[t*IdW +: IdW]  = irq_id_q[t*IdW +: IdW];
        end
      end
    end
  end

  always_comb begin
    cmpl_src = '0;
    for (int t = 0; t < NumTarget; t++) begin
      for (int s = 1; s < NumSrc; s++) begin
        if (complete_i[t] && complete_id_i[t*IdW +: IdW] == IdW'(s)) begin
          cmpl_src[s] = 1'b1;
        end
      end
    end
  end

  for (genvar s = 1; s < NumSrc; s++) begin : g_gw
    gw_state_e       st_q;
    logic            prev_q;
    logic            ovf_q;
    logic [CntW-1:0] cnt_q;
    logic            edge_ev;
    logic            is_edge;
    logic            is_counted;

    assign edge_ev    = intr_src_i[s] & ~prev_q;
    assign is_edge    = (mode_i[2*s +: 2] == 2'b01);
    assign is_counted = (mode_i[2*s +: 2] == 2'b10);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        st_q   <= GwIdle;
        prev_q <= 1'b0;
        ovf_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        prev_q <= intr_src_i[s];

        if (is_counted && edge_ev && st_q != GwIdle && cnt_q == '1) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr_i[s]) begin
          ovf_q <= 1'b0;
        end

        case (st_q)
          GwIdle: begin
            if (!is_edge && !is_counted) begin
              if (intr_src_i[s]) st_q <= GwPending;
            end else if (edge_ev) begin
              st_q <= GwPending;
            end else if (cnt_q != '0) begin
              st_q  <= GwPending;
              cnt_q <= cnt_q - 1'b1;
            end
          end
          GwPending: if (gnt_src[s])  st_q <= GwClaimed;
          GwClaimed: if (cmpl_src[s]) st_q <= GwIdle;
          default:   st_q <= GwIdle;
        endcase

        // Edges arriving while busy are remembered for a later re-pend.
        if (st_q != GwIdle && edge_ev) begin
          if (is_edge) begin
            cnt_q <= CntW'(1);
          end else if (is_counted && cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        if (!is_edge && !is_counted) cnt_q <= '0;
      end
    end

    assign pend[s]      = (st_q == GwPending);
    assign cnt_ovf_o[s] = ovf_q;
  end

  // Strict '>' keeps the lowest ID on ties and excludes priority 0.
  always_comb begin
    best_prio = '0;
    best_id   = '0;
    for (int t = 0; t < NumTarget; t++) begin
      for (int s = 0; s < NumSrc; s++) begin
        if (pend[s] && !gnt_src[s] && ie_i[t*NumSrc + s] &&
            prio_i[s*PrioW +: PrioW] > best_prio[t*PrioW +: PrioW]) begin
          best_prio[t*PrioW +: PrioW] = prio_i[s*PrioW +: PrioW];
          best_id[t*IdW +: IdW]       = IdW'(s);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q    <= '0;
      irq_id_q <= '0;
    end else begin
      irq_id_q <= best_id;
      for (int t = 0; t < NumTarget; t++) begin
        irq_q[t] <= (best_prio[t*PrioW +: PrioW] > threshold_i[t*PrioW +: PrioW]);
      end
    end
  end

  assign ip_o     = pend;
  assign irq_o    = irq_q;
  assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_rv_plic_gw_arb.sv
// Directed bench for rv_plic_gw_arb: level/edge/counted-edge gateways, tie-break,
// dual claim, threshold, overflow flag and asynchronous reset.
module tb_rv_plic_gw_arb;
  localparam int NumSrc    = 32;
  localparam int NumTarget = 2;
  localparam int PrioW     = 3;
  localparam int CntW      = 2;
  localparam int IdW       = 6;

  logic                        clk_i = 1'b0;
  logic                        rst_ni = 1'b0;
  logic [NumSrc-1:0]           intr_src_i = '0;
  logic [2*NumSrc-1:0]         mode_i = '0;
  logic [PrioW*NumSrc-1:0]     prio_i = '0;
  logic [NumSrc*NumTarget-1:0] ie_i = '0;
  logic [PrioW*NumTarget-1:0]  threshold_i = '0;
  logic [NumTarget-1:0]        claim_req_i = '0;
  logic [IdW*NumTarget-1:0]    claim_id_o;
  logic [NumTarget-1:0]        complete_i = '0;
  logic [IdW*NumTarget-1:0]    complete_id_i = '0;
  logic [NumSrc-1:0]           ovf_clr_i = '0;
  logic [NumSrc-1:0]           ip_o;
  logic [NumTarget-1:0]        irq_o;
  logic [IdW*NumTarget-1:0]    irq_id_o;
  logic [NumSrc-1:0]           cnt_ovf_o;

  int n_chk = 0;
  int n_err = 0;

  rv_plic_gw_arb #(
    .NumSrc(NumSrc), .NumTarget(NumTarget), .PrioW(PrioW), .CntW(CntW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .intr_src_i(intr_src_i), .mode_i(mode_i),
    .prio_i(prio_i), .ie_i(ie_i), .threshold_i(threshold_i),
    .claim_req_i(claim_req_i), .claim_id_o(claim_id_o),
    .complete_i(complete_i), .complete_id_i(complete_id_i),
    .ovf_clr_i(ovf_clr_i), .ip_o(ip_o), .irq_o(irq_o),
    .irq_id_o(irq_id_o), .cnt_ovf_o(cnt_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [IdW-1:0] id_of(input int t);
    return irq_id_o[t*IdW +: IdW];
  endfunction

  function automatic logic [IdW-1:0] cid(input int t);
    return claim_id_o[t*IdW +: IdW];
  endfunction

  task automatic set_prio(input int s, input int p);
    prio_i[s*PrioW +: PrioW] = PrioW'(p);
  endtask

  task automatic set_mode(input int s, input logic [1:0] m);
    mode_i[2*s +: 2] = m;
  endtask

  task automatic set_thr(input int t, input int v);
    threshold_i[t*PrioW +: PrioW] = PrioW'(v);
  endtask

  task automatic set_cid(input int t, input int id);
    complete_id_i[t*IdW +: IdW] = IdW'(id);
  endtask

  task automatic pulse(input int s);
    intr_src_i[s] = 1'b1;
    tick();
    intr_src_i[s] = 1'b0;
    tick();
  endtask

  initial begin
    tick();
    tick();
    check("rst_ip",    64'(ip_o), 64'd0);
    check("rst_irq",   64'(irq_o), 64'd0);
    check("rst_id",    64'(irq_id_o), 64'd0);
    check("rst_ovf",   64'(cnt_ovf_o), 64'd0);
    check("rst_claim", 64'(claim_id_o), 64'd0);
    rst_ni = 1'b1;
    tick();

    // level source 5 on target 0
    set_prio(5, 3); ie_i[5] = 1'b1; set_thr(0, 1);
    intr_src_i[5] = 1'b1;
    tick();
    check("lvl_ip",       64'(ip_o[5]), 64'd1);
    check("lvl_irq_early",64'(irq_o), 64'd0);
    tick();
    check("lvl_irq",      64'(irq_o), 64'b01);
    check("lvl_id0",      64'(id_of(0)), 64'd5);
    check("lvl_id1",      64'(id_of(1)), 64'd0);
    claim_req_i = 2'b01;
    #1;
    check("lvl_claim0",   64'(cid(0)), 64'd5);
    check("lvl_claim1",   64'(cid(1)), 64'd0);
    tick();
    claim_req_i = '0;
    check("lvl_ip_claimed", 64'(ip_o[5]), 64'd0);
    check("lvl_id_after",   64'(id_of(0)), 64'd0);
    check("lvl_irq_after",  64'(irq_o), 64'd0);
    check("noreq_claim",    64'(claim_id_o), 64'd0);
    intr_src_i[5] = 1'b0; complete_i = 2'b01; set_cid(0, 5);
    tick();
    complete_i = '0;
    tick();
    check("lvl_done", 64'(ip_o[5]), 64'd0);
    set_prio(5, 0); ie_i[5] = 1'b0;

    // tie-break between 3 and 7
    set_thr(0, 0);
    set_prio(3, 2); set_prio(7, 2); ie_i[3] = 1'b1; ie_i[7] = 1'b1;
    intr_src_i[3] = 1'b1; intr_src_i[7] = 1'b1;
    tick();
    tick();
    check("tie_id",  64'(id_of(0)), 64'd3);
    check("tie_irq", 64'(irq_o[0]), 64'd1);
    claim_req_i = 2'b01;
    #1;
    check("tie_claim3", 64'(cid(0)), 64'd3);
    tick();
    claim_req_i = '0;
    check("tie_next_id", 64'(id_of(0)), 64'd7);
    claim_req_i = 2'b01;
    #1;
    check("tie_claim7", 64'(cid(0)), 64'd7);
    tick();
    claim_req_i = '0;
    check("tie_none", 64'(id_of(0)), 64'd0);
    intr_src_i[3] = 1'b0; intr_src_i[7] = 1'b0;
    complete_i = 2'b11; set_cid(0, 3); set_cid(1, 7);
    tick();
    complete_i = '0;
    tick();
    check("tie_done", 64'(ip_o), 64'd0);
    set_prio(3, 0); set_prio(7, 0); ie_i[3] = 1'b0; ie_i[7] = 1'b0;

    // dual claim of source 4
    set_prio(4, 1); ie_i[4] = 1'b1; ie_i[NumSrc+4] = 1'b1; set_thr(1, 0);
    intr_src_i[4] = 1'b1;
    tick();
    tick();
    check("dual_id0", 64'(id_of(0)), 64'd4);
    check("dual_id1", 64'(id_of(1)), 64'd4);
    claim_req_i = 2'b11;
    #1;
    check("dual_claim0", 64'(cid(0)), 64'd4);
    check("dual_claim1", 64'(cid(1)), 64'd0);
    tick();
    claim_req_i = '0;
    check("dual_ip_claimed", 64'(ip_o[4]), 64'd0);
    complete_i = 2'b10; set_cid(1, 4);
    tick();
    complete_i = '0;
    check("dual_idle",   64'(ip_o[4]), 64'd0);
    tick();
    check("dual_repend", 64'(ip_o[4]), 64'd1);
    intr_src_i[4] = 1'b0;
    tick();
    claim_req_i = 2'b01;
    #1;
    check("dual_reclaim", 64'(cid(0)), 64'd4);
    tick();
    claim_req_i = '0; complete_i = 2'b01; set_cid(0, 4);
    tick();
    complete_i = '0;
    tick();
    check("dual_done", 64'(ip_o), 64'd0);
    set_prio(4, 0); ie_i[4] = 1'b0; ie_i[NumSrc+4] = 1'b0;

    // counted-edge source 9, 2-bit counter
    set_mode(9, 2'b10); set_prio(9, 1); ie_i[9] = 1'b1;
    pulse(9);
    check("cnt_id", 64'(id_of(0)), 64'd9);
    claim_req_i = 2'b01;
    #1;
    check("cnt_claim", 64'(cid(0)), 64'd9);
    tick();
    claim_req_i = '0;
    for (int i = 0; i < 5; i++) pulse(9);
    check("cnt_ovf_set",  64'(cnt_ovf_o[9]), 64'd1);
    check("cnt_claimed",  64'(ip_o[9]), 64'd0);
    for (int r = 0; r < 3; r++) begin
      complete_i = 2'b01; set_cid(0, 9);
      tick();
      complete_i = '0;
      check("cnt_round_idle", 64'(ip_o[9]), 64'd0);
      tick();
      check("cnt_round_pend", 64'(ip_o[9]), 64'd1);
      tick();
      claim_req_i = 2'b01;
      #1;
      check("cnt_round_claim", 64'(cid(0)), 64'd9);
      tick();
      claim_req_i = '0;
    end
    complete_i = 2'b01; set_cid(0, 9);
    tick();
    complete_i = '0;
    tick();
    tick();
    check("cnt_drained",  64'(ip_o[9]), 64'd0);
    check("cnt_ovf_held", 64'(cnt_ovf_o[9]), 64'd1);
    ovf_clr_i[9] = 1'b1;
    tick();
    ovf_clr_i[9] = 1'b0;
    check("cnt_ovf_clr", 64'(cnt_ovf_o[9]), 64'd0);
    set_prio(9, 0); ie_i[9] = 1'b0; set_mode(9, 2'b00);

    // threshold on target 1, source 12
    set_prio(12, 2); ie_i[NumSrc+12] = 1'b1; set_thr(1, 2);
    intr_src_i[12] = 1'b1;
    tick();
    tick();
    check("thr_irq_off", 64'(irq_o[1]), 64'd0);
    check("thr_id",      64'(id_of(1)), 64'd12);
    set_thr(1, 1);
    tick();
    check("thr_irq_on",  64'(irq_o[1]), 64'd1);
    complete_i = 2'b11; set_cid(0, 20); set_cid(1, 12);
    tick();
    complete_i = '0;
    check("thr_cmpl_ign",  64'(ip_o[12]), 64'd1);
    check("thr_cmpl_ign20",64'(ip_o[20]), 64'd0);
    tick();
    check("thr_id_kept",   64'(id_of(1)), 64'd12);

    // reset with source 14 claimed and count 2
    set_mode(14, 2'b10); set_prio(14, 1); ie_i[14] = 1'b1; set_thr(0, 0);
    pulse(14);
    check("rr_id", 64'(id_of(0)), 64'd14);
    claim_req_i = 2'b01;
    #1;
    check("rr_claim", 64'(cid(0)), 64'd14);
    tick();
    claim_req_i = '0;
    pulse(14);
    pulse(14);
    rst_ni = 1'b0;
    #1;
    check("rr_ip",    64'(ip_o), 64'd0);
    check("rr_irq",   64'(irq_o), 64'd0);
    check("rr_id0",   64'(irq_id_o), 64'd0);
    check("rr_ovf",   64'(cnt_ovf_o), 64'd0);
    check("rr_claim0",64'(claim_id_o), 64'd0);
    set_mode(14, 2'b01);
    intr_src_i[14] = 1'b1;
    tick();
    rst_ni = 1'b1;
    tick();
    check("rr_edge_pend", 64'(ip_o[14]), 64'd1);
    tick();
    claim_req_i = 2'b01;
    #1;
    check("rr_edge_claim", 64'(cid(0)), 64'd14);
    tick();
    claim_req_i = '0; complete_i = 2'b01; set_cid(0, 14);
    tick();
    complete_i = '0;
    tick();
    check("rr_no_stale_cnt", 64'(ip_o[14]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/rv_plic_gw_arb.md
Name: rv_plic_gw_arb

Overview:
Parametrised PLIC core combining per-source gateways with per-target priority arbitration and a claim/complete handshake. It is the next generation of the rv_plic gateway and target logic. It adds a per-source trigger mode (level, edge, counted-edge) with a saturating pending-edge counter, and same-cycle multi-target claim resolution. It sits between the synchronised interrupt sources and the register file, which drives the mode, priority, enable, threshold, claim and complete inputs.

Parameters:
NumSrc, 32, number of source slots including reserved slot 0 (ID 0 = "no interrupt")
NumTarget, 2, number of interrupt targets (harts/contexts)
PrioW, 3, priority and threshold width
CntW, 4, pending-edge counter width for counted-edge mode
IdW, $clog2(NumSrc+1), derived ID width, not overridable

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset, asynchronous, active-low
intr_src_i  in  NumSrc  synchronised interrupt sources; bit 0 ignored
mode_i  in  2*NumSrc  per source: 00 level, 01 edge, 10 counted-edge, 11 treated as level
prio_i  in  PrioW*NumSrc  per-source priority; 0 = never interrupts
ie_i  in  NumSrc*NumTarget  per-target enable vector, target t at [t*NumSrc +: NumSrc]
threshold_i  in  PrioW*NumTarget  per-target threshold
claim_req_i  in  NumTarget  single-cycle claim read strobe
claim_id_o  out  IdW*NumTarget  combinational claim result, valid in the strobe cycle
complete_i  in  NumTarget  completion write strobe
complete_id_i  in  IdW*NumTarget  ID being completed
ovf_clr_i  in  NumSrc  clears sticky overflow per source
ip_o  out  NumSrc  pending bits (registered)
irq_o  out  NumTarget  interrupt request per target (registered)
irq_id_o  out  IdW*NumTarget  current best ID per target (registered)
cnt_ovf_o  out  NumSrc  sticky counter-overflow flags

Behaviour:
- Reset values:
  - All outputs 0.
  - All gateways IDLE, counters 0, previous-input samples 0. A source already high at reset release therefore counts as an edge.
  - Reset asserted mid-operation drops all pending and claimed state immediately.
- Source slot 0 is tied off: ip_o[0]=0, never claimed, cnt_ovf_o[0]=0.
- Gateway FSM per source s, states IDLE / PENDING / CLAIMED; ip_o[s]=1 only in PENDING.
- Edge event e[s] = intr_src_i[s] & ~prev[s], where prev is registered every cycle.
- Level mode:
  - IDLE -> PENDING when intr_src_i[s]=1.
  - Input changes in PENDING or CLAIMED are ignored.
- Edge mode:
  - IDLE -> PENDING on e.
  - An e in PENDING or CLAIMED sets a 1-deep latch (count saturates at 1, no overflow flag).
- Counted-edge mode:
  - IDLE with e -> PENDING, count unchanged.
  - IDLE with no e and count>0 -> PENDING, count-1.
  - An e in PENDING or CLAIMED increments the count, saturating at 2^CntW-1.
  - An increment attempted at saturation sets cnt_ovf_o[s]. It stays set until ovf_clr_i[s]; if set and clear coincide, set wins.
- The count is forced to 0 whenever mode is not edge or counted.
- Latency: trigger in cycle N -> ip_o high in N+1 -> irq_o and irq_id_o in N+2.
- PENDING -> CLAIMED on a granted claim.
- CLAIMED -> IDLE on complete_i[t] with complete_id_i[t]==s, from any target t.
  - A complete for a source not in CLAIMED is ignored.
  - After IDLE, re-pending follows the normal IDLE rules in the next cycle: level still high re-pends 1 cycle later; a nonzero count re-pends and decrements.
- Arbitration per target t, over candidates with ip & ie[t] & prio>0:
  - Highest priority wins; ties go to the lowest ID. No candidate gives ID 0.
  - irq_id_o[t] registers the winner every cycle, regardless of threshold.
  - irq_o[t] registers (winner prio > threshold[t]).
- Claim:
  - claim_req_i[t] in cycle N targets id = irq_id_o[t].
  - Granted iff id!=0, source id is PENDING in cycle N, and no lower-index target claims the same id in N.
  - Granted: claim_id_o[t]=id, source -> CLAIMED at N+1. Otherwise claim_id_o[t]=0 and there is no state change.
  - With no strobe, claim_id_o[t]=0.
- The arbiter input in cycle N is masked with this cycle's grant vector, so irq_id_o at N+1 already excludes the claimed source.
- Simultaneous claim grant and complete for the same source in one cycle is impossible; a complete for a PENDING source is ignored.
- prio_i, ie_i and threshold_i changes take effect on the next irq_o / irq_id_o update (1 cycle).

Test Plan:
- Level, NumTarget=2, prio[5]=3, ie[0][5]=1, thr[0]=1: intr_src_i[5] high at cycle 0 -> ip_o[5]=1 at 1; irq_o[0]=1, irq_id_o[0]=5 at 2; target 1 stays 0.
- Tie-break: src 3 and 7 both prio 2, pending, enabled on target 0 -> irq_id_o[0]=3. Claim: claim_id_o=3; next cycle irq_id_o[0]=7.
- Dual claim: both targets enabled for src 4, claim_req_i=2'b11 in same cycle -> claim_id_o[0]=4, claim_id_o[1]=0. Src 4 CLAIMED; a complete from target 1 with ID 4 returns it to IDLE.
- Counted-edge, CntW=2: 5 rising edges while CLAIMED -> count 3, cnt_ovf_o=1. Three complete/claim rounds each re-pend; after the 3rd, IDLE with ip_o=0. ovf_clr_i clears the flag.
- Threshold: prio 2, thr 2 -> irq_o=0, irq_id_o=src. Lower thr to 1 -> irq_o=1 next cycle. A complete of an unclaimed ID changes nothing.
- Reset mid-claim: src CLAIMED with count 2, assert rst_ni low -> all outputs 0 immediately. After release with input high in edge mode -> ip_o=1 one cycle later.
